// File: rtl/fpu_pipe_elastic.sv
// fpu_pipe_elastic: elastic valid/ready delay pipeline with per-stage stall, bubble collapse and flush.
// Optional item counter port enabled by `define FPU_PIPE_OCCUPANCY_EN.  Rev 1.0
`default_nettype none

module fpu_pipe_elastic #(
  parameter int STAGES = 6,
  parameter int WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data
`ifdef FPU_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
`endif
);

  logic [STAGES-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [STAGES];
  logic [STAGES-1:0] w_move;
  logic [STAGES-1:0] w_acc;
  logic              w_in_fire;

  // Ready chain resolved from the output back to the entry so a full pipe
  // that is draining still accepts in the same cycle.
  always_comb begin
    w_move = '0;
    w_acc  = '0;
    w_move[STAGES-1] = w_valid[STAGES-1] & out_ready;
    w_acc[STAGES-1]  = !w_valid[STAGES-1] | w_move[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_move[i] = w_valid[i] & w_acc[i+1];
      w_acc[i]  = !w_valid[i] | w_move[i];
    end
  end

  assign in_ready  = w_acc[0] & !flush & rst;
  assign w_in_fire = in_valid & in_ready;
  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;
    logic             r_v;
    logic [WIDTH-1:0] r_d;

    if (g == 0) begin : g_entry
      assign w_up_valid = w_in_fire;
      assign w_up_data  = in_data;
    end else begin : g_link
      assign w_up_valid = w_valid[g-1];
      assign w_up_data  = w_data[g-1];
    end

    // Payload only loads with a valid item, so bubbles leave data untouched.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (flush) begin
        r_v <= 1'b0;
      end else if (w_acc[g]) begin
        r_v <= w_up_valid;
        if (w_up_valid) begin
          r_d <= w_up_data;
        end
      end
    end

    assign w_valid[g] = r_v;
    assign w_data[g]  = r_d;
  end

`ifdef FPU_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             w_out_fire;
  logic [OCC_W-1:0] r_occ;

  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_pipe_elastic.sv
// tb_fpu_pipe_elastic: table-driven directed checks of fpu_pipe_elastic (STAGES=6, WIDTH=32).
`default_nettype none

module tb_fpu_pipe_elastic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
`ifdef FPU_PIPE_OCCUPANCY_EN
  logic [2:0]  occupancy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t tbl[$];

  fpu_pipe_elastic #(.STAGES(6), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FPU_PIPE_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_od, input int e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  task automatic check_occ(input string nm, input int exp);
`ifdef FPU_PIPE_OCCUPANCY_EN
    chk(nm, 32'(occupancy), 32'(exp));
`endif
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      flush     = tbl[i].fl;
      #1;
      chk($sformatf("%s[%0d].in_ready", nm, i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("%s[%0d].out_valid", nm, i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("%s[%0d].out_data", nm, i), out_data, tbl[i].e_od);
      check_occ($sformatf("%s[%0d].occupancy", nm, i), tbl[i].e_occ);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) begin
      #1;
      chk("reset.in_ready", 32'(in_ready), 32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_data", out_data, 32'd0);
      check_occ("reset.occupancy", 0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Stream: one item per cycle, first output six cycles after first handshake.
    tbl.delete();
    for (int k = 0; k < 12; k++)
      add(1'b1, 32'(k + 1), 1'b1, 1'b0, 1'b1, k >= 6, (k >= 6) ? 32'(k - 5) : 32'd0, (k < 6) ? k : 6);
    do_reset();
    run_table("stream");

    // Fill under stall, then drain with same-cycle ready.
    tbl.delete();
    for (int k = 0; k < 6; k++) add(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, k);
    add(1'b1, 32'hA6, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 6);
    add(1'b1, 32'hA6, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 6);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 6);
    for (int k = 9; k < 14; k++) add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0 + 32'(k - 8), 14 - k);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5, 0);
    do_reset();
    run_table("fill");

    // Bubble collapse: two items separated by idle cycles pack together under stall.
    tbl.delete();
    add(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    for (int k = 1; k < 4; k++) add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1);
    add(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1);
    add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 2);
    for (int k = 6; k < 10; k++) add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 0);
    do_reset();
    run_table("bubble");

    // Flush with four items in flight and a simultaneous input that must be dropped.
    tbl.delete();
    for (int k = 0; k < 4; k++) add(1'b1, 32'h31 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, k);
    add(1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4);
    for (int k = 5; k < 12; k++) add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    do_reset();
    run_table("flush");

    // Flush coinciding with an output handshake; data register keeps its value.
    tbl.delete();
    for (int k = 0; k < 6; k++) add(1'b1, 32'h60 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, k);
    add(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 6);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h60, 0);
    do_reset();
    run_table("flush_hs");

    // Full pass-through: 10 simultaneous in/out handshakes, then drain.
    tbl.delete();
    for (int k = 0; k < 6; k++) add(1'b1, 32'h40 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, k);
    for (int j = 0; j < 10; j++) add(1'b1, 32'h46 + 32'(j), 1'b1, 1'b0, 1'b1, 1'b1, 32'h40 + 32'(j), 6);
    for (int j = 0; j < 6; j++) add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4A + 32'(j), 6 - j);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4F, 0);
    do_reset();
    run_table("passthru");

    // Asynchronous reset between edges with items in flight.
    tbl.delete();
    for (int k = 0; k < 3; k++) add(1'b1, 32'h51 + 32'(k), 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, k);
    for (int k = 3; k < 6; k++) add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 3);
    add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h51, 3);
    do_reset();
    run_table("arst_pre");
    #2;
    rst = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data", out_data, 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    check_occ("arst.occupancy", 0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("arst.hold.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("arst.after[%0d].out_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("arst.after[%0d].in_ready", k), 32'(in_ready), 32'd1);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
